// File: rtl/pifo_dequeue_ctrl.sv
// Dequeue front-end for the root PIFO calendar: paced, insert-aware pop issue
// into a small output FIFO that feeds the packet-buffer reader.
module pifo_dequeue_ctrl #(
  parameter int BUFFER_ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_PTR_WIDTH    = 2,
  parameter int GAP_WIDTH         = 8,
  parameter int STAT_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUFFER_ADDR_WIDTH-1:0] s_axis_buffer_addr,
  input  logic                         s_axis_buffer_addr_valid,
  input  logic                         s_axis_insert_en,
  output logic                         m_axis_pop_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic                         cfg_enable,
  input  logic [GAP_WIDTH-1:0]         cfg_min_gap,
  output logic [STAT_WIDTH-1:0]        stat_pop_count,
  output logic [STAT_WIDTH-1:0]        stat_insert_block_count,
  output logic [FIFO_PTR_WIDTH:0]      fifo_occupancy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [FIFO_PTR_WIDTH:0] FULL_LVL = (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);

  state_t                                       r_state;
  logic [GAP_WIDTH-1:0]                         r_gap_cnt;
  logic [FIFO_DEPTH-1:0][BUFFER_ADDR_WIDTH-1:0] r_mem;
  logic [FIFO_PTR_WIDTH-1:0]                    r_wr_ptr, r_rd_ptr;
  logic [FIFO_PTR_WIDTH:0]                      r_occ;
  logic [STAT_WIDTH-1:0]                        r_pop_cnt, r_blk_cnt;

  logic w_full, w_gap_ok, w_qual, w_pop, w_blk, w_rd;

  // Full is judged on current occupancy only, so tready never reaches pop_en.
  assign w_full   = (r_occ == FULL_LVL);
  assign w_gap_ok = (r_gap_cnt == '0);
  assign w_qual   = !rst && (r_state == RUN) && cfg_enable && s_axis_buffer_addr_valid &&
                    !w_full && w_gap_ok;
  assign w_pop    = w_qual && !s_axis_insert_en;
  assign w_blk    = w_qual && s_axis_insert_en;
  assign w_rd     = (r_occ != '0) && m_axis_tready;

  assign m_axis_pop_en           = w_pop;
  assign m_axis_tvalid           = (r_occ != '0);
  assign m_axis_tdata            = r_mem[r_rd_ptr];
  assign fifo_occupancy          = r_occ;
  assign stat_pop_count          = r_pop_cnt;
  assign stat_insert_block_count = r_blk_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (cfg_enable)  r_state <= RUN;
        RUN:     if (!cfg_enable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gap of 0 or 1 both load 0, giving back-to-back pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (w_pop) begin
      r_gap_cnt <= (cfg_min_gap == '0) ? '0 : cfg_min_gap - GAP_WIDTH'(1);
    end else if (r_gap_cnt != '0) begin
      r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_pop) begin
        r_mem[r_wr_ptr] <= s_axis_buffer_addr;
        r_wr_ptr        <= r_wr_ptr + FIFO_PTR_WIDTH'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + FIFO_PTR_WIDTH'(1);
      case ({w_pop, w_rd})
        2'b10:   r_occ <= r_occ + (FIFO_PTR_WIDTH+1)'(1);
        2'b01:   r_occ <= r_occ - (FIFO_PTR_WIDTH+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_cnt <= '0;
      r_blk_cnt <= '0;
    end else begin
      if (w_pop) r_pop_cnt <= r_pop_cnt + STAT_WIDTH'(1);
      if (w_blk) r_blk_cnt <= r_blk_cnt + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pifo_dequeue_ctrl.sv
// Directed bench for pifo_dequeue_ctrl; popped addresses are scoreboarded and
// checked by an independent output monitor.
module tb_pifo_dequeue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] s_axis_buffer_addr;
  logic        s_axis_buffer_addr_valid;
  logic        s_axis_insert_en;
  logic        m_axis_pop_en;
  logic [11:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        cfg_enable;
  logic [7:0]  cfg_min_gap;
  logic [31:0] stat_pop_count;
  logic [31:0] stat_insert_block_count;
  logic [2:0]  fifo_occupancy;

  pifo_dequeue_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .s_axis_buffer_addr      (s_axis_buffer_addr),
    .s_axis_buffer_addr_valid(s_axis_buffer_addr_valid),
    .s_axis_insert_en        (s_axis_insert_en),
    .m_axis_pop_en           (m_axis_pop_en),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .cfg_enable              (cfg_enable),
    .cfg_min_gap             (cfg_min_gap),
    .stat_pop_count          (stat_pop_count),
    .stat_insert_block_count (stat_insert_block_count),
    .fifo_occupancy          (fifo_occupancy)
  );

  always #5 clk = ~clk;

  logic [11:0] heads[$];
  logic [11:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          pop_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_head();
    s_axis_buffer_addr       = (heads.size() != 0) ? heads[0] : 12'h000;
    s_axis_buffer_addr_valid = (heads.size() != 0);
  endtask

  // One clock: sample pop at negedge, then advance the calendar head after the edge.
  task automatic tick();
    @(negedge clk);
    pop_seen = m_axis_pop_en;
    if (pop_seen) exp_q.push_back(s_axis_buffer_addr);
    @(posedge clk);
    #1;
    if (pop_seen && heads.size() != 0) void'(heads.pop_front());
    drive_head();
  endtask

  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected none at %0t", m_axis_tdata, $time);
      end else begin
        chk("tdata", {20'h0, m_axis_tdata}, {20'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1;
    cfg_enable = 1'b1;
    cfg_min_gap = 8'd0;
    s_axis_insert_en = 1'b0;
    m_axis_tready = 1'b0;
    heads = {12'h00A};
    drive_head();

    // Reset held with head valid and enable set
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pop_en", pop_seen, 1'b0);
      chk("rst_tvalid", m_axis_tvalid, 1'b0);
    end
    chk("rst_occ", fifo_occupancy, 3'd0);
    chk("rst_tdata", m_axis_tdata, 12'h000);
    rst = 1'b0;
    tick();
    chk("rel_c1_pop", pop_seen, 1'b0);
    tick();
    chk("rel_c2_pop", pop_seen, 1'b1);
    chk("rel_tvalid", m_axis_tvalid, 1'b1);
    chk("rel_tdata", m_axis_tdata, 12'h00A);
    m_axis_tready = 1'b1;
    tick();
    chk("rel_occ", fifo_occupancy, 3'd0);

    // Back-to-back drain
    heads = {12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006};
    drive_head();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b2b_pop", pop_seen, 1'b1);
    end
    tick();
    chk("b2b_nopop", pop_seen, 1'b0);
    chk("b2b_popcnt", stat_pop_count, 32'd7);
    chk("b2b_sb_empty", exp_q.size(), 32'd0);

    // Full stall
    m_axis_tready = 1'b0;
    heads.delete();
    for (int i = 0; i < 16; i++) heads.push_back(12'h100 + 12'(i));
    drive_head();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("full_pop", pop_seen, (i < 4) ? 1'b1 : 1'b0);
    end
    chk("full_occ", fifo_occupancy, 3'd4);
    m_axis_tready = 1'b1;
    tick();
    chk("full_rd_nopop", pop_seen, 1'b0);
    chk("full_occ_after_rd", fifo_occupancy, 3'd3);
    m_axis_tready = 1'b0;
    tick();
    chk("full_refill_pop", pop_seen, 1'b1);
    chk("full_occ_refill", fifo_occupancy, 3'd4);
    heads.delete();
    drive_head();
    m_axis_tready = 1'b1;
    repeat (5) tick();
    chk("full_drain_occ", fifo_occupancy, 3'd0);
    chk("full_popcnt", stat_pop_count, 32'd12);
    chk("full_sb_empty", exp_q.size(), 32'd0);

    // Insert collision
    heads = {12'h200};
    drive_head();
    s_axis_insert_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ins_pop", pop_seen, 1'b0);
    end
    chk("ins_blkcnt", stat_insert_block_count, 32'd3);
    s_axis_insert_en = 1'b0;
    tick();
    chk("ins_release_pop", pop_seen, 1'b1);
    tick();
    chk("ins_sb_empty", exp_q.size(), 32'd0);

    // Pacing with gap 5
    cfg_min_gap = 8'd5;
    heads = {12'h300, 12'h301, 12'h302, 12'h303};
    drive_head();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("gap_pop", pop_seen, (i == 0 || i == 5 || i == 10) ? 1'b1 : 1'b0);
    end
    heads.delete();
    drive_head();
    repeat (2) tick();
    chk("gap_sb_empty", exp_q.size(), 32'd0);
    chk("gap_popcnt", stat_pop_count, 32'd16);

    // Asynchronous reset with entries queued
    cfg_min_gap = 8'd0;
    m_axis_tready = 1'b0;
    heads = {12'h400, 12'h401, 12'h402};
    drive_head();
    for (int i = 0; i < 30 && fifo_occupancy != 3'd3; i++) tick();
    chk("mid_fill_occ", fifo_occupancy, 3'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    chk("mid_rst_occ", fifo_occupancy, 3'd0);
    chk("mid_rst_popcnt", stat_pop_count, 32'd0);
    chk("mid_rst_blkcnt", stat_insert_block_count, 32'd0);
    chk("mid_rst_pop_en", m_axis_pop_en, 1'b0);
    exp_q.delete();
    tick();
    chk("mid_rst_hold_pop", pop_seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
